// File: rtl/count_01.sv
// Registered 0/1 balance classifier: popcount of `in` via a balanced adder
// tree, compared against the zero count, result registered once per clock.
module count_01 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [1:0]       result
);

  localparam int CW     = $clog2(WIDTH + 1);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int NLEAF  = 1 << LEVELS;

  localparam logic [1:0] MORE_ZEROS = 2'b00;
  localparam logic [1:0] TIE        = 2'b01;
  localparam logic [1:0] MORE_ONES  = 2'b10;

  logic [CW-1:0] ones;
  logic [CW-1:0] zeros;
  logic [1:0]    result_d;
  logic [1:0]    result_q;

  // Level 0 holds one leaf per bit (zero-padded up to a power of two);
  // each higher level sums adjacent pairs, so depth is log2(WIDTH).
  for (genvar l = 0; l <= LEVELS; l++) begin : lvl_g
    localparam int N = NLEAF >> l;
    logic [CW-1:0] s [N];
    for (genvar i = 0; i < N; i++) begin : node_g
      if (l == 0) begin : leaf_g
        if (i < WIDTH) begin : bit_g
          assign s[i] = CW'(in[i]);
        end else begin : pad_g
          assign s[i] = '0;
        end
      end else begin : sum_g
        assign s[i] = lvl_g[l-1].s[2*i] + lvl_g[l-1].s[2*i+1];
      end
    end
  end

  assign ones  = lvl_g[LEVELS].s[0];
  assign zeros = CW'(WIDTH) - ones;

  always_comb begin
    result_d = MORE_ZEROS;
    if (ones > zeros)       result_d = MORE_ONES;
    else if (ones == zeros) result_d = TIE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) result_q <= MORE_ZEROS;
    else       result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: tb/tb_count_01.sv
// Self-checking bench for count_01: directed boundaries, latency/reset
// timing, exhaustive sweep and random words against a popcount model.
module tb_count_01;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic [1:0]       result;

  int n_checks;
  int n_fail;

  count_01 #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: compare the number of ones against half the word width.
  function automatic logic [1:0] model(input logic [WIDTH-1:0] w);
    int ones;
    ones = $countones(w);
    if (2 * ones > WIDTH)  return 2'b10;
    if (2 * ones == WIDTH) return 2'b01;
    return 2'b00;
  endfunction

  // Drive a word mid-cycle, then check one edge later.
  task automatic apply(input logic [WIDTH-1:0] w, input string tag);
    @(negedge clk);
    in = w;
    @(posedge clk);
    #1;
    check(tag, 32'(result), 32'(model(w)));
  endtask

  initial begin
    logic [WIDTH-1:0] dir [11];
    logic [WIDTH-1:0] w;
    logic [1:0] exp;
    int ties;
    int elevens;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    in       = 8'hFF;

    // Held in reset with all-ones input: result must stay 00 across edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 32'(result), 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("first_after_reset", 32'(result), 32'h2);

    dir = '{8'h00, 8'h01, 8'h07, 8'h0F, 8'hF0, 8'h55, 8'hAA, 8'h3C, 8'h1F, 8'hFE, 8'hFF};
    foreach (dir[i]) apply(dir[i], $sformatf("directed_%02h", dir[i]));

    // Mid-cycle input change must not reach result before the next edge.
    apply(8'h0F, "latency_pre");
    #2;
    in = 8'hFF;
    #1;
    check("latency_hold", 32'(result), 32'h1);
    @(posedge clk);
    #1;
    check("latency_edge", 32'(result), 32'h2);

    // Asynchronous reset mid-cycle clears result without an edge.
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 32'(result), 32'h0);
    @(posedge clk);
    #1;
    check("reset_edge_lost", 32'(result), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    apply(8'hAA, "post_reset");

    // Exhaustive sweep.
    ties    = 0;
    elevens = 0;
    for (int v = 0; v < 256; v++) begin
      w = 8'(v);
      @(negedge clk);
      in = w;
      @(posedge clk);
      #1;
      exp = model(w);
      check($sformatf("sweep_%02h", w), 32'(result), 32'(exp));
      if (result == 2'b01) ties++;
      if (result == 2'b11) elevens++;
    end
    check("tie_count", 32'(ties), 32'd70);
    check("never_11", 32'(elevens), 32'd0);

    // Random words with glitches on `in` before the sampled value settles.
    for (int n = 0; n < 200; n++) begin
      w = 8'($urandom);
      @(negedge clk);
      in = 8'($urandom);
      #1;
      in = 8'($urandom);
      #1;
      in = w;
      @(posedge clk);
      #1;
      check($sformatf("random_%0d", n), 32'(result), 32'(model(w)));
      in = 8'($urandom);
      #2;
      check($sformatf("random_hold_%0d", n), 32'(result), 32'(model(w)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
